output_pro: RTL and testbench

OUTPUT_PRO -- requirements
Module: output_pro

---
 rtl/sdr_pkg.sv | 15 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/output_pro.sv | 92 +++++++++
 tb/tb_output_pro.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR sample path (input and output processors).
package sdr_pkg;

  localparam int IDX_W      = 6;
  localparam int SMP_W      = 4;
  localparam logic [IDX_W-1:0] OOR_IDX = '0;
  localparam int SAMPLE_MIN = -6;
  localparam int SAMPLE_MAX = 5;

  typedef struct packed {
    logic signed [SMP_W-1:0] data;
    logic                    oor;
  } sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; pointers wrap naturally (DEPTH is a power of two).
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/output_pro.sv
// Output processor: decodes quantizer indices to clamped samples, buffers them, counts out-of-range hits.
module output_pro
  import sdr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IDX_W-1:0]            in_idx,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [SMP_W-1:0]     out_data,
  output logic                        out_oor,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        oor_clr,
  output logic [7:0]                  oor_cnt,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int DEC_W = 8;
  localparam logic signed [DEC_W-1:0] MIN_W = DEC_W'(SAMPLE_MIN);
  localparam logic signed [DEC_W-1:0] MAX_W = DEC_W'(SAMPLE_MAX);

  logic signed [DEC_W-1:0] wide;
  sample_t                 dec;
  sample_t                 head;
  logic                    accept;
  logic                    full, empty;
  logic                    rdy_q;
  logic [7:0]              oor_cnt_q, oor_cnt_d;

  // Decode at 8-bit signed width so 2*idx-9 never wraps before clamping.
  always_comb begin
    wide = $signed(DEC_W'(in_idx)) * 8'sd2 - 8'sd9;
    dec  = '0;
    if (in_idx == OOR_IDX) begin
      dec.oor = 1'b1;
    end else if (wide < MIN_W) begin
      dec.data = SMP_W'(MIN_W);
    end else if (wide > MAX_W) begin
      dec.data = SMP_W'(MAX_W);
      dec.oor  = 1'b1;
    end else begin
      dec.data = wide[SMP_W-1:0];
    end
  end

  // rdy_q holds in_ready low during reset and until the first edge after release.
  assign in_ready = rdy_q && !full;
  assign accept   = in_valid && in_ready;

  sync_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_data_i (dec),
    .rd_en_i   (out_ready),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  assign out_valid = !empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_oor   = out_valid ? head.oor  : 1'b0;

  always_comb begin
    oor_cnt_d = oor_cnt_q;
    if (oor_clr)
      oor_cnt_d = '0;
    else if (accept && dec.oor && (oor_cnt_q != '1))
      oor_cnt_d = oor_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      oor_cnt_q <= '0;
    end else begin
      rdy_q     <= 1'b1;
      oor_cnt_q <= oor_cnt_d;
    end
  end

  assign oor_cnt = oor_cnt_q;

endmodule

// File: tb/tb_output_pro.sv
// Directed bench for output_pro with a scoreboard queue and a cycle-level occupancy model.
module tb_output_pro;
  import sdr_pkg::*;

  localparam int DEPTH = 4;

  logic                    clk;
  logic                    rst_n;
  logic [IDX_W-1:0]        in_idx;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [SMP_W-1:0] out_data;
  logic                    out_oor;
  logic                    out_valid;
  logic                    out_ready;
  logic                    oor_clr;
  logic [7:0]              oor_cnt;
  logic [$clog2(DEPTH):0]  level;

  output_pro #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_idx    (in_idx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_oor   (out_oor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oor_clr   (oor_clr),
    .oor_cnt   (oor_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  sample_t sb[$];
  int      cnt_m  = 0;
  bit      rdy_m  = 0;
  bit      last_acc;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] enc(input int v);
    logic [31:0] t;
    t = v;
    return t[3:0];
  endfunction

  function automatic sample_t model(input logic [IDX_W-1:0] idx);
    sample_t s;
    int      v;
    if (idx == 0) begin
      s.data = '0; s.oor = 1'b1;
    end else if (idx == 1) begin
      s.data = 4'(-6); s.oor = 1'b0;
    end else if (idx <= 7) begin
      v = 2 * int'(idx) - 9;
      s.data = 4'(v); s.oor = 1'b0;
    end else begin
      s.data = 4'(5); s.oor = 1'b1;
    end
    return s;
  endfunction

  // Called right after a falling edge with inputs already driven; samples mid-low-phase.
  task automatic tick();
    bit exp_valid, exp_ready, acc, pop;
    sample_t s;
    #2;
    exp_valid = (sb.size() != 0);
    exp_ready = rdy_m && (sb.size() < DEPTH);
    check("level", level, sb.size());
    check("out_valid", out_valid, exp_valid);
    check("in_ready", in_ready, exp_ready);
    check("oor_cnt", oor_cnt, cnt_m);
    if (exp_valid) begin
      check("out_data", out_data[3:0], sb[0].data[3:0]);
      check("out_oor", out_oor, sb[0].oor);
    end else begin
      check("idle_data", out_data[3:0], 0);
      check("idle_oor", out_oor, 0);
    end
    acc = in_valid && exp_ready;
    pop = exp_valid && out_ready;
    if (pop) void'(sb.pop_front());
    if (acc) begin
      s = model(in_idx);
      sb.push_back(s);
    end
    if (oor_clr) cnt_m = 0;
    else if (acc && s.oor && cnt_m < 255) cnt_m++;
    rdy_m    = 1;
    last_acc = acc;
    @(negedge clk);
  endtask

  logic [IDX_W-1:0] bp [5];
  int n;

  initial begin
    rst_n = 1'b0; in_idx = '0; in_valid = 1'b0; out_ready = 1'b0; oor_clr = 1'b0;
    bp[0] = 6'd3; bp[1] = 6'd7; bp[2] = 6'd0; bp[3] = 6'd12; bp[4] = 6'd4;

    // Reset values
    #2;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_cnt", oor_cnt, 0);
    check("rst_data", out_data[3:0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Decode sweep, idx 0..9 streaming through with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_idx = 6'(i);
      tick();
    end
    in_valid = 1'b0;
    check("sweep_last_data", out_data[3:0], enc(5));
    check("sweep_last_oor", out_oor, 1);
    tick();
    tick();

    // Backpressure: fill to DEPTH, fifth index held until space frees
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_idx = bp[i];
      tick();
    end
    in_idx = bp[4];
    tick();
    tick();
    check("bp_level_full", level, 4);
    check("bp_ready_low", in_ready, 0);
    check("bp_head", out_data[3:0], enc(-3));
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 10);
    in_valid = 1'b0;
    check("bp_fifth_accepted", last_acc, 1);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("bp_drained", level, 0);

    // Simultaneous push and pop at level 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_idx = 6'd2; tick();
    in_idx = 6'd6; tick();
    in_valid = 1'b0;
    check("pp_level_before", level, 2);
    in_idx = 6'd5; in_valid = 1'b1; out_ready = 1'b1;
    check("pp_head_old", out_data[3:0], enc(-5));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_level_after", level, 2);
    check("pp_head_next", out_data[3:0], enc(3));
    out_ready = 1'b1;
    repeat (3) tick();

    // Counter saturation and clear priority
    in_idx = 6'd0; in_valid = 1'b1;
    repeat (300) tick();
    check("sat_cnt", oor_cnt, 255);
    oor_clr = 1'b1;
    tick();
    oor_clr = 1'b0;
    check("clr_cnt", oor_cnt, 0);
    in_valid = 1'b0;
    repeat (2) tick();

    // Mid-stream asynchronous reset
    out_ready = 1'b0; in_valid = 1'b1;
    in_idx = 6'd0; tick();
    in_idx = 6'd9; tick();
    in_idx = 6'd4; tick();
    in_valid = 1'b0;
    check("mr_level_before", level, 3);
    check("mr_cnt_before", oor_cnt, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_level", level, 0);
    check("mr_cnt", oor_cnt, 0);
    check("mr_ready", in_ready, 0);
    check("mr_data", out_data[3:0], 0);
    sb.delete();
    cnt_m = 0;
    rdy_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    in_idx = 6'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mr_new_data", out_data[3:0], enc(5));
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
